// File: rtl/win_checker_if.sv
// Panel bus between the board-state block (master) and the win checker (slave).
// Carries the board snapshot request and the scan result back to game control.
interface win_checker_if #(
    parameter int COLS = 7,
    parameter int ROWS = 6
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [COLS-1:0][ROWS-1:0][1:0] panel;
    logic                           start;
    logic                           busy;
    logic                           done;
    logic [1:0]                     winner;
    logic                           draw;
    logic [COL_W-1:0]               win_col;
    logic [ROW_W-1:0]               win_row;
    logic [1:0]                     win_dir;

    modport master (
        output panel, start,
        input  busy, done, winner, draw, win_col, win_row, win_dir
    );

    modport slave (
        input  panel, start,
        output busy, done, winner, draw, win_col, win_row, win_dir
    );
endinterface

// File: rtl/win_checker.sv
// Snapshots the board on start, then walks the cells column-major one per clock,
// reporting the first four-in-a-row found (or a draw when the board is full).
module win_checker #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic          clk,
    input  logic          rst,
    win_checker_if.slave  bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int IDX_W = $clog2(CELLS);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t                         state_q;
    logic [COLS-1:0][ROWS-1:0][1:0] snap_q;
    logic [IDX_W-1:0]               idx_q;
    logic [COL_W-1:0]               col_q;
    logic [ROW_W-1:0]               row_q;
    logic                           full_q;
    logic                           busy_q;
    logic                           done_q;
    logic                           draw_q;
    logic [1:0]                     winner_q;
    logic [1:0]                     win_dir_q;
    logic [COL_W-1:0]               win_col_q;
    logic [ROW_W-1:0]               win_row_q;

    logic [COLS-1:0][ROWS-1:0]      occupied;
    logic [COLS-1:0][ROWS-1:0][3:0] line_hit;

    logic [3:0] cell_hits_d;
    logic [1:0] cell_d;
    logic       cell_occ_d;
    logic       hit_d;
    logic       last_d;
    logic [1:0] dir_d;

    // Every (cell, direction) line is wired statically; lines that would leave
    // the board are tied off at elaboration, so no wrap-around is possible.
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        for (genvar gj = 0; gj < ROWS; gj++) begin : g_row
            assign occupied[gi][gj] = ^snap_q[gi][gj];
            for (genvar gd = 0; gd < 4; gd++) begin : g_dir
                localparam int DX = (gd == 1) ? 0 : 1;
                localparam int DY = (gd == 0) ? 0 : ((gd == 3) ? -1 : 1);
                localparam int EI = gi + (WIN_LEN - 1) * DX;
                localparam int EJ = gj + (WIN_LEN - 1) * DY;
                if (EI < COLS && EJ >= 0 && EJ < ROWS) begin : g_in
                    logic [WIN_LEN-1:0] eq;
                    for (genvar gk = 0; gk < WIN_LEN; gk++) begin : g_k
                        assign eq[gk] = (snap_q[gi + gk * DX][gj + gk * DY] == snap_q[gi][gj]);
                    end
                    assign line_hit[gi][gj][gd] = (&eq) & occupied[gi][gj];
                end else begin : g_out
                    assign line_hit[gi][gj][gd] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        cell_hits_d = line_hit[col_q][row_q];
        cell_d      = snap_q[col_q][row_q];
        cell_occ_d  = occupied[col_q][row_q];
        hit_d       = |cell_hits_d;
        last_d      = (idx_q == IDX_W'(CELLS - 1));
        // Direction priority: horiz, vert, diag, anti.
        dir_d = 2'd0;
        if (cell_hits_d[0])      dir_d = 2'd0;
        else if (cell_hits_d[1]) dir_d = 2'd1;
        else if (cell_hits_d[2]) dir_d = 2'd2;
        else if (cell_hits_d[3]) dir_d = 2'd3;
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start) begin
            snap_q <= bus.panel;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            winner_q  <= 2'd0;
            draw_q    <= 1'b0;
            win_col_q <= '0;
            win_row_q <= '0;
            win_dir_q <= 2'd0;
            idx_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            full_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        winner_q  <= 2'd0;
                        draw_q    <= 1'b0;
                        win_col_q <= '0;
                        win_row_q <= '0;
                        win_dir_q <= 2'd0;
                        idx_q     <= '0;
                        col_q     <= '0;
                        row_q     <= '0;
                        full_q    <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit_d) begin
                        winner_q  <= cell_d;
                        win_col_q <= col_q;
                        win_row_q <= row_q;
                        win_dir_q <= dir_d;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        state_q   <= REPORT;
                    end else if (last_d) begin
                        draw_q  <= full_q & cell_occ_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= REPORT;
                    end else begin
                        full_q <= full_q & cell_occ_d;
                        idx_q  <= idx_q + IDX_W'(1);
                        if (row_q == ROW_W'(ROWS - 1)) begin
                            row_q <= '0;
                            col_q <= col_q + COL_W'(1);
                        end else begin
                            row_q <= row_q + ROW_W'(1);
                        end
                    end
                end
                REPORT: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.winner  = winner_q;
    assign bus.draw    = draw_q;
    assign bus.win_col = win_col_q;
    assign bus.win_row = win_row_q;
    assign bus.win_dir = win_dir_q;
endmodule

// File: tb/tb_win_checker.sv
// Directed bench for win_checker: hand-built boards with known first-hit cells,
// a full no-win board, and start/panel/reset disturbance during a scan.
module tb_win_checker;
    typedef logic [6:0][5:0][1:0] board_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    win_checker_if #(.COLS(7), .ROWS(6)) bus ();

    win_checker #(.COLS(7), .ROWS(6), .WIN_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic board_t draw_board();
        board_t b;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 6; j++)
                b[3'(i)][3'(j)] = ((((i / 2) + j) % 2) == 0) ? 2'b01 : 2'b10;
        return b;
    endfunction

    // Reference: first winning colour in column-major scan order, or 00.
    function automatic logic [1:0] model_winner(input board_t b);
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 6; j++) begin
                logic [1:0] c;
                c = b[3'(i)][3'(j)];
                if (c == 2'b01 || c == 2'b10) begin
                    for (int d = 0; d < 4; d++) begin
                        int dx, dy;
                        bit ok;
                        dx = (d == 1) ? 0 : 1;
                        dy = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
                        ok = 1'b1;
                        for (int k = 0; k < 4; k++) begin
                            int ii, jj;
                            ii = i + k * dx;
                            jj = j + k * dy;
                            if (ii < 0 || ii > 6 || jj < 0 || jj > 5) ok = 1'b0;
                            else if (b[3'(ii)][3'(jj)] != c) ok = 1'b0;
                        end
                        if (ok) return c;
                    end
                end
            end
        end
        return 2'b00;
    endfunction

    function automatic logic model_full(input board_t b);
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 6; j++)
                if (b[3'(i)][3'(j)] != 2'b01 && b[3'(i)][3'(j)] != 2'b10) return 1'b0;
        return 1'b1;
    endfunction

    function automatic board_t red_vertical();
        board_t b;
        b = '0;
        for (int j = 2; j < 6; j++) b[3][3'(j)] = 2'b01;
        return b;
    endfunction

    function automatic board_t green_horizontal();
        board_t b;
        b = '0;
        for (int i = 1; i < 5; i++) b[3'(i)][5] = 2'b10;
        return b;
    endfunction

    // Pulses start, then reports the cycle offset of done (-1 on timeout).
    task automatic run_scan(input board_t p, output int done_at, output int busy_bad,
                            output logic busy_at_done, output logic done_after);
        bus.panel = p;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        done_at = -1;
        busy_bad = 0;
        busy_at_done = 1'bx;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done === 1'b1) begin
                done_at = c;
                busy_at_done = bus.busy;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
            @(negedge clk);
        end
        @(negedge clk);
        done_after = bus.done;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        bus.panel = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.winner !== 2'b00) begin errors++; $display("FAIL reset_winner got %b want 00", bus.winner); end
        checks++; if (bus.draw !== 1'b0) begin errors++; $display("FAIL reset_draw got %b want 0", bus.draw); end
        checks++; if ({bus.win_col, bus.win_row, bus.win_dir} !== 8'd0) begin errors++; $display("FAIL reset_win_pos got %0d/%0d/%0d want 0/0/0", bus.win_col, bus.win_row, bus.win_dir); end
        rst = 1'b1;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_empty();
        int d, bb; logic bd, da;
        run_scan('0, d, bb, bd, da);
        checks++; if (d !== 43) begin errors++; $display("FAIL empty_done_at got %0d want 43", d); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL empty_busy_low_cycles got %0d want 0", bb); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL empty_busy_at_done got %b want 0", bd); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL empty_done_width got %b want 0", da); end
        checks++; if (bus.winner !== 2'b00 || bus.draw !== 1'b0) begin errors++; $display("FAIL empty_result got winner=%b draw=%b want 00/0", bus.winner, bus.draw); end
        $display("test_empty done_at=%0d winner=%b draw=%b", d, bus.winner, bus.draw);
    endtask

    task automatic test_vertical();
        int d, bb; logic bd, da;
        run_scan(red_vertical(), d, bb, bd, da);
        checks++; if (d !== 22) begin errors++; $display("FAIL vert_done_at got %0d want 22", d); end
        checks++; if (bus.winner !== 2'b01) begin errors++; $display("FAIL vert_winner got %b want 01", bus.winner); end
        checks++; if (bus.win_col !== 3'd3 || bus.win_row !== 3'd2) begin errors++; $display("FAIL vert_anchor got %0d,%0d want 3,2", bus.win_col, bus.win_row); end
        checks++; if (bus.win_dir !== 2'b01) begin errors++; $display("FAIL vert_dir got %b want 01", bus.win_dir); end
        checks++; if (bb !== 0 || da !== 1'b0) begin errors++; $display("FAIL vert_busy_done got busy_low=%0d done_after=%b want 0/0", bb, da); end
        $display("test_vertical done_at=%0d winner=%b at %0d,%0d dir=%b", d, bus.winner, bus.win_col, bus.win_row, bus.win_dir);
    endtask

    task automatic test_horizontal();
        int d, bb; logic bd, da;
        run_scan(green_horizontal(), d, bb, bd, da);
        checks++; if (d !== 13) begin errors++; $display("FAIL horiz_done_at got %0d want 13", d); end
        checks++; if (bus.winner !== 2'b10) begin errors++; $display("FAIL horiz_winner got %b want 10", bus.winner); end
        checks++; if (bus.win_col !== 3'd1 || bus.win_row !== 3'd5) begin errors++; $display("FAIL horiz_anchor got %0d,%0d want 1,5", bus.win_col, bus.win_row); end
        checks++; if (bus.win_dir !== 2'b00) begin errors++; $display("FAIL horiz_dir got %b want 00", bus.win_dir); end
        $display("test_horizontal done_at=%0d winner=%b at %0d,%0d dir=%b", d, bus.winner, bus.win_col, bus.win_row, bus.win_dir);
    endtask

    task automatic test_anti();
        int d, bb; logic bd, da;
        board_t b;
        b = '0;
        b[0][5] = 2'b01; b[1][4] = 2'b01; b[2][3] = 2'b01; b[3][2] = 2'b01;
        run_scan(b, d, bb, bd, da);
        checks++; if (d !== 7) begin errors++; $display("FAIL anti_done_at got %0d want 7", d); end
        checks++; if (bus.winner !== 2'b01) begin errors++; $display("FAIL anti_winner got %b want 01", bus.winner); end
        checks++; if (bus.win_col !== 3'd0 || bus.win_row !== 3'd5) begin errors++; $display("FAIL anti_anchor got %0d,%0d want 0,5", bus.win_col, bus.win_row); end
        checks++; if (bus.win_dir !== 2'b11) begin errors++; $display("FAIL anti_dir got %b want 11", bus.win_dir); end
        $display("test_anti done_at=%0d winner=%b at %0d,%0d dir=%b", d, bus.winner, bus.win_col, bus.win_row, bus.win_dir);
    endtask

    task automatic test_draw();
        int d, bb; logic bd, da;
        board_t b;
        logic [1:0] ew;
        logic ed;
        b  = draw_board();
        ew = model_winner(b);
        ed = (ew == 2'b00) && model_full(b);
        run_scan(b, d, bb, bd, da);
        checks++; if (d !== 43) begin errors++; $display("FAIL draw_done_at got %0d want 43", d); end
        checks++; if (bus.winner !== ew) begin errors++; $display("FAIL draw_winner got %b want %b", bus.winner, ew); end
        checks++; if (bus.draw !== ed) begin errors++; $display("FAIL draw_flag got %b want %b", bus.draw, ed); end
        $display("test_draw done_at=%0d winner=%b draw=%b", d, bus.winner, bus.draw);
    endtask

    task automatic test_not_full();
        int d, bb; logic bd, da;
        board_t b;
        logic [1:0] ew;
        logic ed;
        b = draw_board();
        b[6][0] = 2'b00;
        ew = model_winner(b);
        ed = (ew == 2'b00) && model_full(b);
        run_scan(b, d, bb, bd, da);
        checks++; if (d !== 43) begin errors++; $display("FAIL notfull_done_at got %0d want 43", d); end
        checks++; if (bus.winner !== ew || bus.draw !== ed) begin errors++; $display("FAIL notfull_result got winner=%b draw=%b want %b/%b", bus.winner, bus.draw, ew, ed); end
        $display("test_not_full done_at=%0d winner=%b draw=%b", d, bus.winner, bus.draw);
    endtask

    task automatic test_disturb();
        int d, extra, bb; logic bd, da;
        d = -1;
        bus.panel = red_vertical();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            bus.start = (c == 3 || c == 5);
            if (c == 8) bus.panel = green_horizontal();
            if (bus.done === 1'b1) begin
                d = c;
                bus.start = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (d !== 22) begin errors++; $display("FAIL disturb_done_at got %0d want 22", d); end
        checks++; if (bus.winner !== 2'b01 || bus.win_col !== 3'd3 || bus.win_row !== 3'd2 || bus.win_dir !== 2'b01) begin
            errors++; $display("FAIL disturb_result got %b %0d,%0d %b want 01 3,2 01", bus.winner, bus.win_col, bus.win_row, bus.win_dir); end
        extra = 0;
        repeat (50) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL disturb_extra_scan got %0d active cycles want 0", extra); end
        checks++; if (bus.winner !== 2'b01) begin errors++; $display("FAIL disturb_result_stable got %b want 01", bus.winner); end
        $display("test_disturb done_at=%0d winner=%b", d, bus.winner);

        bus.panel = red_vertical();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            if (c == 10) rst = 1'b0;
            if (c == 11) rst = 1'b1;
            if (c < 11) @(negedge clk);
        end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_busy_done got %b/%b want 0/0", bus.busy, bus.done); end
        checks++; if (bus.winner !== 2'b00 || bus.draw !== 1'b0) begin errors++; $display("FAIL midreset_result got %b/%b want 00/0", bus.winner, bus.draw); end
        checks++; if ({bus.win_col, bus.win_row, bus.win_dir} !== 8'd0) begin errors++; $display("FAIL midreset_win_pos got %0d/%0d/%0d want 0/0/0", bus.win_col, bus.win_row, bus.win_dir); end
        extra = 0;
        repeat (50) begin
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) extra++;
            @(negedge clk);
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", extra); end
        run_scan(green_horizontal(), d, bb, bd, da);
        checks++; if (d !== 13 || bus.winner !== 2'b10 || bus.win_col !== 3'd1 || bus.win_row !== 3'd5) begin
            errors++; $display("FAIL midreset_fresh got done=%0d %b %0d,%0d want 13 10 1,5", d, bus.winner, bus.win_col, bus.win_row); end
        $display("test_disturb fresh done_at=%0d winner=%b", d, bus.winner);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.panel = '0;
        test_reset();
        test_empty();
        test_vertical();
        test_horizontal();
        test_anti();
        test_draw();
        test_not_full();
        test_disturb();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
